lake_spec: RTL and testbench

Statically scheduled single-write / single-read memory tile. A flat configuration vector programs one write port and one read port. Each port is an affine iteration domain with an affine schedule (cycle of each access) and an affine address (word touched). The block sits in a CGRA memory tile and needs no valid/ready handshake: all traffic is fixed by configuration and a shared cycle counter.

---
 rtl/lakespec_pkg.sv | 37 +++
 rtl/lakespec_port_ctrl.sv | 82 ++++++++
 rtl/lake_spec.sv | 74 +++++++
 tb/tb_lake_spec.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/lakespec_pkg.sv
// Shared constants, configuration layout and port state for the lake_spec memory tile.
package lakespec_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned MEM_DEPTH  = 256;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned NUM_DIMS   = 3;
    localparam int unsigned FIELD_W    = 16;

    // Per-port configuration block and field offsets inside it
    localparam int unsigned PORT_BLOCK       = 176;
    localparam int unsigned WR_BASE          = 0;
    localparam int unsigned RD_BASE          = 176;
    localparam int unsigned OFF_EXTENT       = 0;
    localparam int unsigned OFF_SCHED_OFFSET = 48;
    localparam int unsigned OFF_SCHED_STRIDE = 64;
    localparam int unsigned OFF_ADDR_OFFSET  = 112;
    localparam int unsigned OFF_ADDR_STRIDE  = 128;

    typedef logic [FIELD_W-1:0] field_t;

    // Packed MSB-first, so extent[0] lands at bit 0 and the struct maps
    // directly onto a 176-bit slice of the configuration vector.
    typedef struct packed {
        field_t [NUM_DIMS-1:0] addr_stride;
        field_t                addr_offset;
        field_t [NUM_DIMS-1:0] sched_stride;
        field_t                sched_offset;
        field_t [NUM_DIMS-1:0] extent;
    } port_cfg_t;

    typedef enum logic {
        PS_RUN  = 1'b0,
        PS_DONE = 1'b1
    } port_state_t;

endpackage

// File: rtl/lakespec_port_ctrl.sv
// Affine iteration domain for one access port: iterators, schedule, address, done.
module lakespec_port_ctrl
    import lakespec_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [FIELD_W-1:0] cycle_count,
    input  port_cfg_t          cfg,
    output logic               fire,
    output logic [ADDR_W-1:0]  addr
);

    port_state_t                      state;
    port_state_t                      state_next;
    logic [NUM_DIMS-1:0][FIELD_W-1:0] iter;
    logic [NUM_DIMS-1:0][FIELD_W-1:0] iter_next;
    logic [FIELD_W-1:0]               sched;
    logic [FIELD_W-1:0]               addr_full;
    logic                             wrap_all;
    logic                             unused_addr_hi;

    // Schedule cycle and word address of the current iteration point
    always_comb begin
        sched     = cfg.sched_offset;
        addr_full = cfg.addr_offset;
        for (int unsigned d = 0; d < NUM_DIMS; d++) begin
            sched     = sched + FIELD_W'(iter[d] * cfg.sched_stride[d]);
            addr_full = addr_full + FIELD_W'(iter[d] * cfg.addr_stride[d]);
        end
    end

    assign addr           = addr_full[ADDR_W-1:0];
    assign unused_addr_hi = ^addr_full[FIELD_W-1:ADDR_W];

    // Next iteration point: dim 0 innermost, carry ripples outward
    always_comb begin
        iter_next = iter;
        wrap_all  = 1'b1;
        for (int unsigned d = 0; d < NUM_DIMS; d++) begin
            if (wrap_all) begin
                if (iter[d] == cfg.extent[d]) begin
                    iter_next[d] = '0;
                end else begin
                    iter_next[d] = iter[d] + 1'b1;
                    wrap_all     = 1'b0;
                end
            end
        end
    end

    // Port state register
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state <= PS_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Fire decision and transition to done once every dim wraps together
    always_comb begin
        state_next = state;
        fire       = 1'b0;
        if (state == PS_RUN && cycle_count == sched && rst_n && !flush) begin
            fire = 1'b1;
            if (wrap_all) begin
                state_next = PS_DONE;
            end
        end
    end

    // Iterators advance only on a fire
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            iter <= '0;
        end else if (fire) begin
            iter <= iter_next;
        end
    end

endmodule

// File: rtl/lake_spec.sv
// Statically scheduled single-write / single-read memory tile.
module lake_spec
    import lakespec_pkg::*;
#(
    parameter int unsigned CONFIG_MEMORY_SIZE = 512
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
    input  logic [DATA_WIDTH-1:0]         port_0,
    output logic [DATA_WIDTH-1:0]         port_1
);

    logic [FIELD_W-1:0]    cycle_count;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    port_cfg_t             wr_cfg;
    port_cfg_t             rd_cfg;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [ADDR_W-1:0]     wr_addr;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  unused_cfg;

    assign wr_cfg     = port_cfg_t'(config_memory[WR_BASE +: PORT_BLOCK]);
    assign rd_cfg     = port_cfg_t'(config_memory[RD_BASE +: PORT_BLOCK]);
    assign unused_cfg = ^config_memory[CONFIG_MEMORY_SIZE-1:RD_BASE+PORT_BLOCK];

    // Shared schedule time base
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
        end
    end

    lakespec_port_ctrl u_wr_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .cycle_count (cycle_count),
        .cfg         (wr_cfg),
        .fire        (wr_fire),
        .addr        (wr_addr)
    );

    lakespec_port_ctrl u_rd_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .cycle_count (cycle_count),
        .cfg         (rd_cfg),
        .fire        (rd_fire),
        .addr        (rd_addr)
    );

    // Storage write; never cleared
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= port_0;
        end
    end

    // Registered read; same-edge write is not yet visible, giving read-first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            port_1 <= '0;
        end else if (rd_fire) begin
            port_1 <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_lake_spec.sv
// Directed scoreboard bench for lake_spec.
module tb_lake_spec;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [511:0] config_memory;
    logic [15:0]  port_0;
    logic [15:0]  port_1;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    int   cc      = 0;

    always #5 clk = ~clk;

    lake_spec #(.CONFIG_MEMORY_SIZE(512)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .config_memory (config_memory),
        .port_0        (port_0),
        .port_1        (port_1)
    );

    function automatic logic [175:0] blk(int e0, int e1, int e2, int so, int ss0, int ss1, int ss2,
                                         int ao, int as0, int as1, int as2);
        logic [175:0] b;
        b = '0;
        b[0   +: 16] = 16'(e0);
        b[16  +: 16] = 16'(e1);
        b[32  +: 16] = 16'(e2);
        b[48  +: 16] = 16'(so);
        b[64  +: 16] = 16'(ss0);
        b[80  +: 16] = 16'(ss1);
        b[96  +: 16] = 16'(ss2);
        b[112 +: 16] = 16'(ao);
        b[128 +: 16] = 16'(as0);
        b[144 +: 16] = 16'(as1);
        b[160 +: 16] = 16'(as2);
        return b;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int cyc, input logic [15:0] val);
        exp_t e;
        e.cyc = cyc;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic set_cfg(input logic [175:0] wr, input logic [175:0] rd);
        config_memory = {{5{32'hA5C3_5A3C}}, rd, wr};
    endtask

    task automatic reset_dut();
        rst_n  = 1'b0;
        flush  = 1'b0;
        port_0 = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_port_1", port_1, 16'h0000);
        check("rst_cycle_count", dut.cycle_count, 16'h0000);
        rst_n = 1'b1;
        cc    = 0;
        sb.delete();
    endtask

    // mode 0: 2k, 1: 2k+1, 2: collision data, 3: 0xA0+k
    task automatic run(input string tag, input int n, input int mode);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       port_0 = 16'(2 * cc);
                1:       port_0 = 16'(2 * cc + 1);
                2:       port_0 = (cc == 3) ? 16'h1234 : 16'h0000;
                default: port_0 = 16'(16'hA0 + cc);
            endcase
            @(posedge clk);
            #1;
            if (sb.size() > 0 && sb[0].cyc == cc) begin
                e = sb.pop_front();
                check($sformatf("%s_c%0d", tag, cc), port_1, e.val);
            end
            cc++;
        end
        check({tag, "_sb_empty"}, 16'(sb.size()), 16'h0000);
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        port_0        = '0;
        config_memory = '0;

        // Straight delay: write k at cycle k, read it back at cycle 8+k
        set_cfg(blk(7, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), blk(7, 0, 0, 8, 1, 0, 0, 0, 1, 0, 0));
        reset_dut();
        for (int c = 0; c < 8; c++) push(c, 16'h0000);
        for (int k = 0; k < 8; k++) push(8 + k, 16'(2 * k));
        for (int c = 16; c < 20; c++) push(c, 16'd14);
        run("delay", 20, 0);

        // 2-D transpose
        set_cfg(blk(3, 3, 0, 0, 1, 4, 0, 0, 1, 4, 0), blk(3, 3, 0, 16, 1, 4, 0, 0, 4, 1, 0));
        reset_dut();
        for (int c = 0; c < 16; c++) push(c, 16'h0000);
        for (int j = 0; j < 16; j++) push(16 + j, 16'(2 * (4 * (j % 4) + j / 4)));
        push(32, 16'd30);
        push(33, 16'd30);
        run("xpose", 34, 0);

        // Flush mid-run of straight delay, restart with new data
        set_cfg(blk(7, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), blk(7, 0, 0, 8, 1, 0, 0, 0, 1, 0, 0));
        reset_dut();
        for (int c = 0; c < 5; c++) push(c, 16'h0000);
        run("preflush", 5, 0);
        flush = 1'b1;
        repeat (2) begin
            port_0 = 16'hBEEF;
            @(posedge clk);
            #1;
            check("flush_cycle_count", dut.cycle_count, 16'h0000);
            check("flush_port_1", port_1, 16'h0000);
        end
        flush = 1'b0;
        cc    = 0;
        for (int c = 0; c < 8; c++) push(c, 16'h0000);
        for (int k = 0; k < 8; k++) push(8 + k, 16'(2 * k + 1));
        for (int c = 16; c < 20; c++) push(c, 16'd15);
        run("postflush", 20, 1);

        // Read-first collision on addr 0 at cycle 3
        set_cfg(blk(1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0), blk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0));
        reset_dut();
        for (int c = 0; c < 4; c++) push(c, 16'h0000);
        for (int c = 4; c < 7; c++) push(c, 16'h1234);
        run("collide", 7, 2);

        // Address wrap: words 255 then 0
        set_cfg(blk(1, 0, 0, 0, 1, 0, 0, 255, 1, 0, 0), blk(1, 0, 0, 2, 1, 0, 0, 255, 1, 0, 0));
        reset_dut();
        push(0, 16'h0000);
        push(1, 16'h0000);
        push(2, 16'h00A0);
        for (int c = 3; c < 7; c++) push(c, 16'h00A1);
        run("wrap", 7, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
